ads8688_scan_seq: RTL and testbench
===================================

# ads8688_scan_seq

Auto-scan sequencer for the ADS8688 SPI controller. Walks a latched channel-enable mask and issues one manual-channel command per frame to `ADS8688_manchn` through `manchn_start`/`chsel`. On each `manchn_done` it captures `ch_data`. Each sample is tagged with its channel number and pushed into a small result FIFO read by the host logic. The block accounts for the ADC's one-frame result latency: frame N returns the sample selected in frame N‑1.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: result FIFO entries; power of two, 2–64.
- `NUM_CH`, 8: channels scanned; fixed at 8 for the ADS8688.

Ports:
- `clk`  in  1  system clock; same clock as `ADS8688_manchn`.
- `arst`  in  1  reset, asynchronous, active-high.
- `scan_start`  in  1  one-cycle pulse; starts a scan.
- `scan_stop`  in  1  one-cycle pulse; ends a continuous scan.
- `scan_cont`  in  1  sampled at `scan_start`; 1 = continuous, 0 = single pass.
- `ch_mask`  in  8  channel enables; bit n = channel n; sampled at `scan_start`.
- `manchn_start`  out  1  one-cycle frame request to the SPI controller.
- `chsel`  out  16  command word for the frame.
- `manchn_done`  in  1  frame-complete flag from the controller.
- `ch_data`  in  16  conversion result from the controller.
- `rd_en`  in  1  FIFO pop.
- `rd_data`  out  19  show-ahead head entry, `{ch[2:0], sample[15:0]}`.
- `rd_empty`  out  1  FIFO empty.
- `fifo_full`  out  1  FIFO full.
- `overflow`  out  1  sticky flag; a sample was lost.
- `busy`  out  1  scan in progress.

## Operation
- Command encoding:
  - Channel n: `chsel = 16'hC000 | (n << 10)`. Channel 0 = C000, channel 1 = C400, channel 7 = DC00.
  - Flush frame: NO_OP, `chsel = 16'h0000`.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, NEXT.
- IDLE:
  - `scan_start` with `ch_mask != 0`: latch mask and mode, clear `overflow`, set `cur` to the lowest enabled channel, clear `prev_vld`, go to ISSUE.
  - `scan_start` with `ch_mask == 0`: ignored.
- ISSUE: drive `chsel` for `cur`, or NO_OP if this is the flush frame. Pulse `manchn_start` for one cycle, then go to WAIT.
- WAIT: `chsel` held stable. Leave on a rising edge of `manchn_done`, detected against a registered copy of it, then go to CAPTURE.
- CAPTURE:
  - If `prev_vld`, push `{prev_ch, ch_data}`.
  - Then `prev_ch <= cur`, `prev_vld <= 1` (0 after the flush frame).
  - The first frame of every scan returns stale data and is discarded.
- NEXT:
  - After the flush frame: go to IDLE.
  - Single mode, `cur` is the highest enabled channel: next frame is the flush frame.
  - Continuous mode, no stop pending: advance `cur` to the next enabled channel above `cur`, wrapping to the lowest. A one-bit mask repeats the same channel.
  - Continuous mode, stop pending: next frame is the flush frame.
- `scan_stop`:
  - Records a pending stop in any non-IDLE state.
  - Ignored in IDLE and in single mode.
- `scan_start` while `busy` is ignored.
- FIFO: pointers are `log2(FIFO_DEPTH)+1` bits wide; full/empty come from comparing the MSBs.
  - `rd_en` while empty: no effect.
  - Push while full with simultaneous `rd_en`: both succeed.
  - Push while full without a read: governed by Configuration; `overflow` set.

## Timing
- Reset values: `manchn_start`=0, `chsel`=16'h0000, `busy`=0, `rd_empty`=1, `fifo_full`=0, `overflow`=0, `rd_data`=0, FSM=IDLE, pointers=0.
- `scan_start` at cycle T:
  - `busy`=1 at T+1.
  - `manchn_start` high during T+1, with `chsel` valid in the same cycle.
- Edge of `manchn_done` seen at cycle D: push at D+1, `rd_empty` falls at D+2, next `manchn_start` at D+3.
- Single scan with k enabled channels: exactly k+1 frames and k pushes. `busy` falls one cycle after the flush CAPTURE.
- `rd_data` is valid whenever `rd_empty`=0; it updates the cycle after `rd_en`.
- `arst` mid-scan: immediate return to reset values. Any partial frame in the controller is abandoned; the controller is reset from the same source.

## Configuration
- `ADS8688_SEQ_OVF_OVERWRITE_EN`:
  - Defined: a push into a full FIFO with no read overwrites the oldest entry; the read pointer advances. FIFO stays full and holds the newest samples.
  - Undefined: the new sample is dropped and the FIFO is unchanged.
  - `overflow` is set in both cases.

## Test plan
- Single scan, `ch_mask`=8'h05 → chsel sequence C000, C800, 0000; FIFO holds {0,d1} then {2,d2}, where d1 and d2 are the `ch_data` of frames 2 and 3; `busy` falls after frame 3.
- `ch_mask`=0 with a `scan_start` pulse → no `manchn_start`; `busy` stays 0.
- Continuous, `ch_mask`=8'h82, stop after frame 4 → chsel C400, DC00, C400, DC00, 0000; 4 entries tagged 1, 7, 1, 7.
- FIFO_DEPTH=8, single scan with 8'hFF twice and no reads → 8 entries, `fifo_full`=1, `overflow`=1. Without the macro the head is still ch0 of the first scan; with it the head is ch0 of the second scan.
- `arst` pulsed during WAIT of frame 2 → all outputs at reset values next cycle; a following `scan_start` restarts from the lowest enabled channel.
- `rd_en` while empty and simultaneous push/pop while full → no pointer corruption, entry count correct.

Source files
------------

// File: rtl/ads8688_scan_seq.sv
// Auto-scan sequencer for the ADS8688 SPI controller: walks a channel mask, issues
// manual-channel frames and stores channel-tagged results in a small FIFO.
// Optional build macro: ADS8688_SEQ_OVF_OVERWRITE_EN (overwrite oldest entry on overflow).
module ads8688_scan_seq #(
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_CH     = 8
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        scan_start,
  input  logic        scan_stop,
  input  logic        scan_cont,
  input  logic [7:0]  ch_mask,
  output logic        manchn_start,
  output logic [15:0] chsel,
  input  logic        manchn_done,
  input  logic [15:0] ch_data,
  input  logic        rd_en,
  output logic [18:0] rd_data,
  output logic        rd_empty,
  output logic        fifo_full,
  output logic        overflow,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_NEXT} state_t;

  state_t      state, state_nx;
  logic [7:0]  mask_q;
  logic        cont_q;
  logic        stop_pend;
  logic        flush_q;
  logic        prev_vld;
  logic [2:0]  cur;
  logic [2:0]  prev_ch;
  logic        done_p1;
  logic        push;
  logic        pop;
  logic        wr_en;
  logic        rd_adv;
  logic        ovf_evt;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [18:0] mem [FIFO_DEPTH];

  function automatic logic [15:0] ch_cmd(input logic [2:0] ch);
    ch_cmd = 16'hC000 | (16'(ch) << 10);
  endfunction

  function automatic logic [2:0] lowest_en(input logic [7:0] m);
    lowest_en = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) lowest_en = 3'(i);
  endfunction

  function automatic logic [2:0] highest_en(input logic [7:0] m);
    highest_en = 3'd0;
    for (int i = 0; i < NUM_CH; i++)
      if (m[i]) highest_en = 3'(i);
  endfunction

  // Scanning downward leaves the nearest enabled channel above c; i == NUM_CH is c itself.
  function automatic logic [2:0] next_en(input logic [7:0] m, input logic [2:0] c);
    int idx;
    next_en = c;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(c) + i) % NUM_CH;
      if (m[idx]) next_en = 3'(idx);
    end
  endfunction

  always_comb begin
    state_nx     = state;
    manchn_start = 1'b0;
    push         = 1'b0;
    case (state)
      S_IDLE:    if (scan_start && ch_mask != 8'h00) state_nx = S_ISSUE;
      S_ISSUE: begin
        manchn_start = 1'b1;
        state_nx     = S_WAIT;
      end
      S_WAIT:    if (manchn_done && !done_p1) state_nx = S_CAPTURE;
      S_CAPTURE: begin
        push     = prev_vld;
        state_nx = S_NEXT;
      end
      S_NEXT:    state_nx = flush_q ? S_IDLE : S_ISSUE;
      default:   state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE) && !(state == S_NEXT && flush_q);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= S_IDLE;
      mask_q    <= 8'h00;
      cont_q    <= 1'b0;
      stop_pend <= 1'b0;
      flush_q   <= 1'b0;
      prev_vld  <= 1'b0;
      cur       <= 3'd0;
      prev_ch   <= 3'd0;
      done_p1   <= 1'b0;
      chsel     <= 16'h0000;
      overflow  <= 1'b0;
    end else begin
      state   <= state_nx;
      done_p1 <= manchn_done;
      if (ovf_evt) overflow <= 1'b1;
      if (scan_stop && state != S_IDLE && cont_q) stop_pend <= 1'b1;
      case (state)
        S_IDLE: if (scan_start && ch_mask != 8'h00) begin
          mask_q    <= ch_mask;
          cont_q    <= scan_cont;
          stop_pend <= 1'b0;
          flush_q   <= 1'b0;
          prev_vld  <= 1'b0;
          overflow  <= 1'b0;
          cur       <= lowest_en(ch_mask);
          chsel     <= ch_cmd(lowest_en(ch_mask));
        end
        // The sample returned now belongs to the channel selected one frame earlier.
        S_CAPTURE: begin
          prev_ch  <= cur;
          prev_vld <= !flush_q;
        end
        S_NEXT: if (!flush_q) begin
          if (cont_q ? stop_pend : (cur == highest_en(mask_q))) begin
            flush_q <= 1'b1;
            chsel   <= 16'h0000;
          end else begin
            cur   <= next_en(mask_q, cur);
            chsel <= ch_cmd(next_en(mask_q, cur));
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_empty  = (wr_ptr == rd_ptr);
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = rd_en && !rd_empty;
  assign ovf_evt   = push && fifo_full && !rd_en;

`ifdef ADS8688_SEQ_OVF_OVERWRITE_EN
  assign wr_en  = push;
  assign rd_adv = pop || (push && fifo_full);
`else
  assign wr_en  = push && (!fifo_full || pop);
  assign rd_adv = pop;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {prev_ch, ch_data};
  end

  assign rd_data = rd_empty ? 19'd0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ads8688_scan_seq.sv
// Self-checking bench for ads8688_scan_seq: a simple frame-controller model answers
// each manchn_start; expected commands and FIFO entries are queued per scan.
module tb_ads8688_scan_seq;

  logic        clk = 1'b0;
  logic        arst;
  logic        scan_start, scan_stop, scan_cont;
  logic [7:0]  ch_mask;
  logic        manchn_start;
  logic [15:0] chsel;
  logic        manchn_done;
  logic [15:0] ch_data;
  logic        rd_en;
  logic [18:0] rd_data;
  logic        rd_empty, fifo_full, overflow, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int fnum     = 0;
  int dly      = 0;

  logic [15:0] exp_cmd[$];
  logic [18:0] exp_ent[$];

  always #5 clk = ~clk;

  ads8688_scan_seq #(.FIFO_DEPTH(8), .NUM_CH(8)) dut (
    .clk(clk), .arst(arst), .scan_start(scan_start), .scan_stop(scan_stop),
    .scan_cont(scan_cont), .ch_mask(ch_mask), .manchn_start(manchn_start),
    .chsel(chsel), .manchn_done(manchn_done), .ch_data(ch_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_empty(rd_empty), .fifo_full(fifo_full),
    .overflow(overflow), .busy(busy)
  );

  // Controller model: answers each frame a few cycles later with a numbered sample.
  always @(posedge clk or posedge arst) begin
    if (arst) begin
      dly         <= 0;
      manchn_done <= 1'b0;
    end else begin
      manchn_done <= 1'b0;
      if (manchn_start) dly <= 4;
      else if (dly == 1) begin
        manchn_done <= 1'b1;
        ch_data     <= {8'hA5, 8'(fnum)};
        fnum        <= fnum + 1;
        dly         <= 0;
      end else if (dly != 0) dly <= dly - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (manchn_start && !arst) begin
      n_starts++;
      if (exp_cmd.size() == 0) check("cmd_unexpected", {16'h0, chsel}, 32'hFFFF_FFFF);
      else check("chsel", {16'h0, chsel}, {16'h0, exp_cmd.pop_front()});
    end
  end

  task automatic plan(input logic [7:0] m, input int n);
    int chs[$];
    int k;
    int base;
    for (int c = 0; c < 8; c++) if (m[c]) chs.push_back(c);
    base = fnum;
    for (int i = 0; i < n; i++) begin
      k = chs[i % chs.size()];
      exp_cmd.push_back(16'hC000 | (16'(k) << 10));
      exp_ent.push_back({3'(k), 8'hA5, 8'(base + 1 + i)});
    end
    exp_cmd.push_back(16'h0000);
  endtask

  task automatic start(input logic [7:0] m, input logic c);
    @(negedge clk);
    ch_mask    = m;
    scan_cont  = c;
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    check("busy_t1", {31'd0, busy}, {31'd0, (m != 8'h00)});
    check("start_t1", {31'd0, manchn_start}, {31'd0, (m != 8'h00)});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    check("scan_done", {31'd0, busy}, 32'd0);
    check("cmds_used", exp_cmd.size(), 32'd0);
  endtask

  task automatic wait_starts(input int target);
    for (int i = 0; i < 2000 && n_starts < target; i++) @(negedge clk);
    check("frame_wait", {31'd0, (n_starts >= target)}, 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && !manchn_done; i++) @(negedge clk);
    check("done_wait", {31'd0, manchn_done}, 32'd1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("not_empty", {31'd0, rd_empty}, 32'd0);
      if (exp_ent.size() == 0) check("ent_unexpected", {13'd0, rd_data}, 32'hFFFF_FFFF);
      else check("rd_data", {13'd0, rd_data}, {13'd0, exp_ent.pop_front()});
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    check("empty_after", {31'd0, rd_empty}, 32'd1);
    check("ents_used", exp_ent.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, {31'd0, manchn_start}, 32'd0);
    check({tag, "_chsel"}, {16'd0, chsel}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_empty"}, {31'd0, rd_empty}, 32'd1);
    check({tag, "_full"}, {31'd0, fifo_full}, 32'd0);
    check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    check({tag, "_rdata"}, {13'd0, rd_data}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    arst = 1'b1; scan_start = 1'b0; scan_stop = 1'b0; scan_cont = 1'b0;
    ch_mask = 8'h00; rd_en = 1'b0; ch_data = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    arst = 1'b0;
    @(negedge clk);

    // Read while empty must not disturb pointers.
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("rd_empty_noop", {31'd0, rd_empty}, 32'd1);
    check("rd_empty_data", {13'd0, rd_data}, 32'd0);

    // Single scan, mask 05.
    plan(8'h05, 2);
    start(8'h05, 1'b0);
    wait_idle();
    check("ovf_single", {31'd0, overflow}, 32'd0);
    drain(2);

    // Empty mask is ignored.
    s0 = n_starts;
    start(8'h00, 1'b0);
    repeat (10) @(negedge clk);
    check("mask0_frames", n_starts - s0, 32'd0);
    check("mask0_busy", {31'd0, busy}, 32'd0);

    // Continuous 82 with stop during frame 4.
    s0 = n_starts;
    plan(8'h82, 4);
    start(8'h82, 1'b1);
    wait_starts(s0 + 4);
    @(negedge clk);
    scan_stop = 1'b1;
    @(negedge clk);
    scan_stop = 1'b0;
    wait_idle();
    drain(4);

    // Two full scans with no reads: overflow.
    plan(8'hFF, 8);
    start(8'hFF, 1'b0);
    wait_idle();
    check("full_first", {31'd0, fifo_full}, 32'd1);
    check("ovf_first", {31'd0, overflow}, 32'd0);
    plan(8'hFF, 8);
    start(8'hFF, 1'b0);
    wait_idle();
    check("full_second", {31'd0, fifo_full}, 32'd1);
    check("ovf_second", {31'd0, overflow}, 32'd1);
`ifdef ADS8688_SEQ_OVF_OVERWRITE_EN
    repeat (8) void'(exp_ent.pop_front());
`else
    repeat (8) void'(exp_ent.pop_back());
`endif
    drain(8);

    // Simultaneous push and pop while full.
    plan(8'hFF, 8);
    start(8'hFF, 1'b0);
    wait_idle();
    plan(8'h01, 1);
    start(8'h01, 1'b0);
    wait_done();
    @(negedge clk);
    wait_done();
    @(negedge clk);
    check("pp_full", {31'd0, fifo_full}, 32'd1);
    check("pp_head", {13'd0, rd_data}, {13'd0, exp_ent.pop_front()});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    wait_idle();
    check("pp_full_after", {31'd0, fifo_full}, 32'd1);
    check("pp_ovf", {31'd0, overflow}, 32'd0);
    drain(8);

    // Asynchronous reset during WAIT of frame 2, then restart.
    s0 = n_starts;
    plan(8'h06, 2);
    start(8'h06, 1'b0);
    wait_starts(s0 + 2);
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    check_reset_outputs("arst");
    arst = 1'b0;
    exp_cmd.delete();
    exp_ent.delete();
    @(negedge clk);
    plan(8'h06, 2);
    start(8'h06, 1'b0);
    wait_idle();
    drain(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
